// File: rtl/instr_fetch_pkg.sv
// Shared definitions for the instruction fetch unit.
// Holds the FSM encoding, next-PC selects, special opcodes and the reset PC.
package instr_fetch_pkg;

    typedef enum logic [1:0] {
        S_REQ   = 2'd0,
        S_VALID = 2'd1,
        S_HALT  = 2'd2
    } fetch_state_t;

    localparam logic [1:0] PC_SRC_SEQ    = 2'b00;
    localparam logic [1:0] PC_SRC_BRANCH = 2'b01;
    localparam logic [1:0] PC_SRC_JUMP   = 2'b10;
    localparam logic [1:0] PC_SRC_RSVD   = 2'b11;

    localparam logic [5:0] OP_HALT = 6'h3F;
    localparam logic [5:0] OP_ANDI = 6'h0C;
    localparam logic [5:0] OP_ORI  = 6'h0D;
    localparam logic [5:0] OP_XORI = 6'h0E;
    localparam logic [5:0] OP_LUI  = 6'h0F;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

    // Logical-immediate instructions take a zero-extended immediate.
    function automatic logic is_zero_ext_op(input logic [5:0] op);
        return (op == OP_ANDI) || (op == OP_ORI) || (op == OP_XORI) || (op == OP_LUI);
    endfunction

endpackage

// File: rtl/instr_fetch_decode.sv
// Combinational field slicing of the held instruction and immediate-extension select.
module instr_decode
    import instr_fetch_pkg::*;
(
    input  logic [31:0] i_ir,
    output logic [5:0]  o_opcode,
    output logic [4:0]  o_rs,
    output logic [4:0]  o_rt,
    output logic [4:0]  o_rd,
    output logic [5:0]  o_funct,
    output logic [15:0] o_immediate,
    output logic        o_ext_sel
);

    assign o_opcode    = i_ir[31:26];
    assign o_rs        = i_ir[25:21];
    assign o_rt        = i_ir[20:16];
    assign o_rd        = i_ir[15:11];
    assign o_funct     = i_ir[5:0];
    assign o_immediate = i_ir[15:0];
    assign o_ext_sel   = !is_zero_ext_op(i_ir[31:26]);

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch: requests the word at PC, holds it in IR until consumed,
// then advances PC by sequential, branch or jump rules; stops on the halt opcode.
module instr_fetch
    import instr_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic        CLK,
    input  logic        Reset,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    input  logic        instr_ready,
    input  logic [1:0]  pc_src,
    input  logic [31:0] ext_imm,
    output logic        instr_valid,
    output logic [31:0] instr,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    output logic [5:0]  opcode,
    output logic [4:0]  rs,
    output logic [4:0]  rt,
    output logic [4:0]  rd,
    output logic [5:0]  funct,
    output logic [15:0] immediate,
    output logic        ExtSel,
    output logic        halted
);

    fetch_state_t r_state;
    logic [31:0]  r_pc;
    logic [31:0]  r_ir;
    logic [31:0]  w_pc_plus4;
    logic [31:0]  w_target;
    logic [31:0]  w_next_pc;
    logic [5:0]   w_opcode;

    assign w_pc_plus4 = r_pc + 32'd4;

    always_comb begin
        w_target = w_pc_plus4;
        case (pc_src)
            PC_SRC_BRANCH: w_target = w_pc_plus4 + (ext_imm << 2);
            PC_SRC_JUMP:   w_target = {w_pc_plus4[31:28], r_ir[25:0], 2'b00};
            default:       w_target = w_pc_plus4;
        endcase
        w_next_pc = {w_target[31:2], 2'b00};
    end

    always_ff @(posedge CLK) begin
        if (Reset) begin
            r_state <= S_REQ;
            r_pc    <= RESET_PC;
            r_ir    <= 32'd0;
        end else begin
            case (r_state)
                S_REQ: begin
                    if (mem_ack) begin
                        r_ir    <= mem_rdata;
                        r_state <= S_VALID;
                    end
                end
                S_VALID: begin
                    if (instr_ready) begin
                        r_pc    <= w_next_pc;
                        r_state <= (w_opcode == OP_HALT) ? S_HALT : S_REQ;
                    end
                end
                S_HALT:  r_state <= S_HALT;
                default: r_state <= S_REQ;
            endcase
        end
    end

    // Gating with Reset keeps the request low while reset is held and lets it
    // rise in the very first cycle after reset is released.
    assign mem_req     = (r_state == S_REQ) && !Reset;
    assign mem_addr    = r_pc;
    assign instr_valid = (r_state == S_VALID);
    assign halted      = (r_state == S_HALT);
    assign instr       = r_ir;
    assign pc          = r_pc;
    assign pc_plus4    = w_pc_plus4;
    assign opcode      = w_opcode;

    instr_decode u_decode (
        .i_ir        (r_ir),
        .o_opcode    (w_opcode),
        .o_rs        (rs),
        .o_rt        (rt),
        .o_rd        (rd),
        .o_funct     (funct),
        .o_immediate (immediate),
        .o_ext_sel   (ExtSel)
    );

endmodule

// File: tb/tb_instr_fetch.sv
// Randomized self-checking bench for instr_fetch against a transaction-level PC/IR model.
module tb_instr_fetch;

    logic        CLK = 1'b0;
    logic        Reset = 1'b1;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ack = 1'b0;
    logic [31:0] mem_rdata = 32'd0;
    logic        instr_ready = 1'b0;
    logic [1:0]  pc_src = 2'b00;
    logic [31:0] ext_imm = 32'd0;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic [5:0]  opcode;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [5:0]  funct;
    logic [15:0] immediate;
    logic        ExtSel;
    logic        halted;

    int n_checks = 0;
    int n_errors = 0;

    logic [31:0] m_pc;
    logic [31:0] m_ir;

    always #5 CLK = ~CLK;

    instr_fetch dut (
        .CLK         (CLK),
        .Reset       (Reset),
        .mem_req     (mem_req),
        .mem_addr    (mem_addr),
        .mem_ack     (mem_ack),
        .mem_rdata   (mem_rdata),
        .instr_ready (instr_ready),
        .pc_src      (pc_src),
        .ext_imm     (ext_imm),
        .instr_valid (instr_valid),
        .instr       (instr),
        .pc          (pc),
        .pc_plus4    (pc_plus4),
        .opcode      (opcode),
        .rs          (rs),
        .rt          (rt),
        .rd          (rd),
        .funct       (funct),
        .immediate   (immediate),
        .ExtSel      (ExtSel),
        .halted      (halted)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        Reset = 1'b1;
        mem_ack = 1'b0;
        instr_ready = 1'b0;
        step();
        step();
        check("rst_mem_req", {31'd0, mem_req}, 32'd0);
        check("rst_valid", {31'd0, instr_valid}, 32'd0);
        check("rst_halted", {31'd0, halted}, 32'd0);
        check("rst_pc", pc, 32'd0);
        check("rst_ir", instr, 32'd0);
        Reset = 1'b0;
        #1;
        m_pc = 32'd0;
        m_ir = 32'd0;
        check("rel_mem_req", {31'd0, mem_req}, 32'd1);
        $display("reset released pc=%h", pc);
    endtask

    // Serve one fetch from the memory model with a given ack delay, then check IR and fields.
    task automatic fetch(input logic [31:0] word, input int delay);
        logic [5:0] exp_op;
        for (int i = 0; i < delay; i++) begin
            check("req_wait", {31'd0, mem_req}, 32'd1);
            check("req_addr", mem_addr, m_pc);
            check("req_novalid", {31'd0, instr_valid}, 32'd0);
            step();
        end
        check("req_addr_ack", mem_addr, m_pc);
        mem_ack = 1'b1;
        mem_rdata = word;
        step();
        mem_ack = 1'b0;
        mem_rdata = $urandom;
        m_ir = word;
        exp_op = 6'(word >> 26);
        check("valid_lat", {31'd0, instr_valid}, 32'd1);
        check("valid_noreq", {31'd0, mem_req}, 32'd0);
        check("ir", instr, m_ir);
        check("pc", pc, m_pc);
        check("pc_plus4", pc_plus4, m_pc + 32'd4);
        check("opcode", {26'd0, opcode}, {26'd0, exp_op});
        check("rs", {27'd0, rs}, (word >> 21) & 32'h1F);
        check("rt", {27'd0, rt}, (word >> 16) & 32'h1F);
        check("rd", {27'd0, rd}, (word >> 11) & 32'h1F);
        check("funct", {26'd0, funct}, word & 32'h3F);
        check("imm", {16'd0, immediate}, word & 32'hFFFF);
        check("extsel", {31'd0, ExtSel}, (exp_op >= 6'h0C && exp_op <= 6'h0F) ? 32'd0 : 32'd1);
        $display("fetch addr=%h word=%h delay=%0d", m_pc, word, delay);
    endtask

    // Hold the instruction for some cycles (with a stray ack), then consume it.
    task automatic consume(input logic [1:0] src, input logic [31:0] imm, input int hold);
        logic [31:0] p4;
        logic [31:0] nxt;
        for (int i = 0; i < hold; i++) begin
            mem_ack = (i == 0);
            mem_rdata = $urandom;
            pc_src = 2'($urandom_range(0, 3));
            step();
            mem_ack = 1'b0;
            check("hold_ir", instr, m_ir);
            check("hold_pc", pc, m_pc);
            check("hold_valid", {31'd0, instr_valid}, 32'd1);
            check("hold_noreq", {31'd0, mem_req}, 32'd0);
        end
        p4 = m_pc + 32'd4;
        if (src == 2'b01)
            nxt = p4 + imm * 32'd4;
        else if (src == 2'b10)
            nxt = (p4 & 32'hF000_0000) | ((m_ir & 32'h03FF_FFFF) * 32'd4);
        else
            nxt = p4;
        nxt = nxt & 32'hFFFF_FFFC;
        pc_src = src;
        ext_imm = imm;
        instr_ready = 1'b1;
        step();
        instr_ready = 1'b0;
        ext_imm = $urandom;
        m_pc = nxt;
        if ((m_ir >> 26) == 32'h3F) begin
            check("halt_flag", {31'd0, halted}, 32'd1);
            check("halt_noreq", {31'd0, mem_req}, 32'd0);
        end else begin
            check("next_req", {31'd0, mem_req}, 32'd1);
            check("next_addr", mem_addr, m_pc);
            check("next_novalid", {31'd0, instr_valid}, 32'd0);
        end
        $display("consume src=%0d imm=%h hold=%0d next_pc=%h", src, imm, hold, m_pc);
    endtask

    initial begin
        logic [31:0] w;
        logic [31:0] imm;
        do_reset();

        fetch(32'h3401_FFFF, 3);
        check("ori_extsel", {31'd0, ExtSel}, 32'd0);
        check("ori_imm", {16'd0, immediate}, 32'h0000_FFFF);
        consume(2'b00, 32'd0, 5);

        fetch(32'h2001_FFFF, 0);
        check("addi_extsel", {31'd0, ExtSel}, 32'd1);
        consume(2'b00, 32'd0, 0);

        fetch(32'h0800_0040, 1);
        consume(2'b10, 32'd0, 1);
        check("jump_0x100", mem_addr, 32'h0000_0100);

        fetch(32'h1022_0003, 0);
        consume(2'b01, 32'hFFFF_FFFE, 2);
        check("branch_back", mem_addr, 32'h0000_00FC);

        fetch(32'h0BFF_FFFF, 2);
        consume(2'b10, 32'd0, 0);
        check("jump_top", mem_addr, 32'h0FFF_FFFC);
        fetch(32'h0800_0040, 0);
        consume(2'b10, 32'd0, 0);
        check("jump_region", mem_addr, 32'h1000_0100);

        fetch(32'h1000_0000, 0);
        imm = (32'hFFFF_FFFC - (m_pc + 32'd4)) >> 2;
        consume(2'b01, imm, 0);
        check("branch_max", mem_addr, 32'hFFFF_FFFC);
        fetch(32'h0000_0020, 1);
        consume(2'b11, $urandom, 1);
        check("pc_wrap", mem_addr, 32'h0000_0000);

        for (int k = 0; k < 40; k++) begin
            w = $urandom;
            if ((w >> 26) == 32'h3F) w = w & 32'h03FF_FFFF;
            fetch(w, int'($urandom_range(0, 4)));
            consume(2'($urandom_range(0, 3)), $urandom, int'($urandom_range(0, 3)));
        end

        step();
        Reset = 1'b1;
        mem_ack = 1'b1;
        mem_rdata = 32'hDEAD_BEEF;
        step();
        Reset = 1'b0;
        mem_ack = 1'b0;
        #1;
        m_pc = 32'd0;
        check("rst_ack_pc", pc, 32'd0);
        check("rst_ack_valid", {31'd0, instr_valid}, 32'd0);
        check("rst_ack_ir", instr, 32'd0);
        check("rst_ack_req", {31'd0, mem_req}, 32'd1);
        $display("reset with concurrent ack pc=%h", pc);

        fetch(32'hFC00_0000, 1);
        consume(2'b00, 32'd0, 0);
        for (int i = 0; i < 4; i++) begin
            mem_ack = 1'($urandom_range(0, 1));
            instr_ready = 1'($urandom_range(0, 1));
            step();
            check("halt_stay", {31'd0, halted}, 32'd1);
            check("halt_req", {31'd0, mem_req}, 32'd0);
            check("halt_valid", {31'd0, instr_valid}, 32'd0);
            check("halt_pc", pc, m_pc);
        end
        mem_ack = 1'b0;
        instr_ready = 1'b0;
        do_reset();
        check("unhalt", {31'd0, halted}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
